// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter and the receiver.
package uart_pkg;

   // 8N1 frame: start bit, 8 data bits, stop bit
   localparam int unsigned FRAME_BITS = 10;
   localparam logic        START_BIT  = 1'b0;
   localparam logic        STOP_BIT   = 1'b1;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StFetch = 2'd1,
      StLoad  = 2'd2,
      StSend  = 2'd3
   } tx_state_e;

   // Truncating division; both sides of the link must agree on this
   function automatic int unsigned clocks_per_bit(input int unsigned freq,
                                                  input int unsigned baud);
      return freq / baud;
   endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period counter: counts 0..CLOCKS_PER_BIT-1 while enabled and flags the last cycle.
module uart_baud_counter #(
   parameter int unsigned CLOCKS_PER_BIT = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic bit_done
);

   localparam int unsigned CntW = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(CLOCKS_PER_BIT - 1);

   logic [CntW-1:0] clk_cnt_q;
   logic            at_max;

   assign at_max   = (clk_cnt_q == CntMax);
   assign bit_done = enable && at_max;

   // Counter register; clear wins over counting, wraps to 0 at the bit boundary
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_cnt_q <= '0;
      end else if (clear) begin
         clk_cnt_q <= '0;
      end else if (enable) begin
         clk_cnt_q <= at_max ? '0 : clk_cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/uart_fifo_tx.sv
// FIFO-fed UART transmitter: pops one byte at a time and sends it as an 8N1 frame.
module uart_fifo_tx
   import uart_pkg::*;
#(
   parameter int unsigned CLOCK_FREQ = 125_000_000,
   parameter int unsigned BAUD_RATE  = 115_200,
   parameter int unsigned WIDTH      = 8   // must be 8 for an 8N1 frame
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             fifo_empty,
   output logic             fifo_rd_en,
   input  logic [WIDTH-1:0] fifo_dout,
   output logic             serial_out,
   output logic             busy
);

   localparam int unsigned CLOCKS_PER_BIT = clocks_per_bit(CLOCK_FREQ, BAUD_RATE);
   localparam logic [3:0]  LastBit        = 4'(FRAME_BITS - 1);

   tx_state_e        state_q, state_d;
   logic [WIDTH+1:0] shift_q, shift_d;
   logic [3:0]       bit_cnt_q, bit_cnt_d;
   logic             cnt_clear;
   logic             cnt_en;
   logic             bit_done;

   uart_baud_counter #(
      .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
   ) u_baud_counter (
      .clk     (clk),
      .rst     (rst),
      .clear   (cnt_clear),
      .enable  (cnt_en),
      .bit_done(bit_done)
   );

   // Next-state logic for the FSM, shift register and bit counter
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      cnt_clear = 1'b0;
      cnt_en    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (!fifo_empty) state_d = StFetch;
         end
         StFetch: begin
            state_d = StLoad;
         end
         StLoad: begin
            // FIFO data is valid only in this cycle
            shift_d   = {STOP_BIT, fifo_dout, START_BIT};
            bit_cnt_d = '0;
            cnt_clear = 1'b1;
            state_d   = StSend;
         end
         StSend: begin
            cnt_en = 1'b1;
            if (bit_done) begin
               shift_d = {1'b1, shift_q[WIDTH+1:1]};
               if (bit_cnt_q == LastBit) begin
                  state_d = StIdle;
               end else begin
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State, shift register and bit counter; reset leaves the line idle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         shift_q   <= '1;
         bit_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
      end
   end

   // Outputs decode the state register only, so fifo_empty never reaches fifo_rd_en
   assign fifo_rd_en = (state_q == StFetch);
   assign busy       = (state_q != StIdle);
   assign serial_out = (state_q == StSend) ? shift_q[0] : STOP_BIT;

endmodule
